// File: rtl/cnn_mem_pkg.sv
// Shared types and default sizes for the CNN weight/tile buffer.
package cnn_mem_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 256;

    // Sequencer states: host traffic is served in all of them.
    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        STREAM,
        DONE
    } mem_state_t;

endpackage

// File: rtl/cnn_skid_buf.sv
// Two-entry valid/ready skid buffer with fall-through when empty.
// Words arrive one cycle after the array read is issued. An empty buffer
// presents the incoming word directly. Otherwise the stored head is shown.
// The caller must never push into a full buffer unless it pops that cycle.
module cnn_skid_buf
    import cnn_mem_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        level
);

    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic              pop;

    assign out_valid = (level != 2'd0) || in_valid;
    assign out_data  = (level != 2'd0) ? head : in_data;
    assign pop       = out_valid && out_ready;

    // Occupancy and entry update: push, pop, or both in the same cycle.
    // NOTE: state registers use non-blocking assignments so every flop in
    // the block samples pre-edge values, exactly like the hardware.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (level)
                2'd0: begin
                    if (in_valid && !pop) begin
                        head  <= in_data;
                        level <= 2'd1;
                    end
                end
                2'd1: begin
                    if (in_valid && pop) begin
                        head <= in_data;
                    end else if (in_valid) begin
                        tail  <= in_data;
                        level <= 2'd2;
                    end else if (pop) begin
                        level <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head <= tail;
                        if (in_valid) begin
                            tail <= in_data;
                        end else begin
                            level <= 2'd1;
                        end
                    end
                end
                default: level <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/cnn_mem_bank.sv
// Single-ported CNN weight/tile buffer. The host reads and writes it over a
// memory-mapped port. A clear sequencer zeroes the array, and a burst
// streamer drains words over valid/ready. Host accesses always win the port.
module cnn_mem_bank
    import cnn_mem_pkg::*;
#(
    parameter int   DATA_W = DEFAULT_DATA_W,
    parameter int   DEPTH  = DEFAULT_DEPTH,
    localparam int  ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    input  logic              clear,
    input  logic              strm_start,
    input  logic [ADDR_W-1:0] strm_base,
    input  logic [ADDR_W:0]   strm_len,
    output logic [DATA_W-1:0] strm_data,
    output logic              strm_valid,
    input  logic              strm_ready,
    output logic              busy,
    output logic              strm_done
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

    mem_state_t        state;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W:0]   iss_left;
    logic [ADDR_W:0]   rem;

    logic              host_wr;
    logic              host_rd;
    logic              host_acc;
    logic              clr_we;
    logic              strm_re;
    logic              strm_rd_q;
    logic              pop;
    logic [1:0]        level;
    logic [2:0]        occ;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] mem [DEPTH];

    assign host_wr  = chipselect && write;
    assign host_rd  = chipselect && read && !write;
    assign host_acc = host_wr || host_rd;

    // Words the buffer must hold after the next edge if nothing is popped
    // then: stored words plus the read in flight, minus this cycle's pop.
    assign pop     = strm_valid && strm_ready;
    assign occ     = {1'b0, level} + {2'b00, strm_rd_q} - {2'b00, pop};
    assign clr_we  = (state == CLEAR) && !host_acc;
    assign strm_re = (state == STREAM) && !host_acc &&
                     (iss_left != '0) && (occ < 3'd2);

    // One shared port: the host address wins, else the sequencer address.
    assign ram_addr  = host_acc ? address : seq_addr;
    assign ram_we    = host_wr || clr_we;
    assign ram_re    = host_rd || strm_re;
    assign ram_wdata = host_wr ? writedata : '0;

    // Array write port.
    // NOTE: the array has no reset so it maps onto block RAM; its contents
    // are undefined until written or cleared.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    // Registered array read, shared by host reads and stream reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_q <= '0;
        end else if (ram_re) begin
            ram_q <= mem[ram_addr];
        end
    end

    // Read qualifiers: host response valid, stream word arriving.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdatavalid <= 1'b0;
            strm_rd_q     <= 1'b0;
        end else begin
            readdatavalid <= host_rd;
            strm_rd_q     <= strm_re;
        end
    end

    assign readdata = ram_q;

    // Clear/stream sequencer with registered busy and done outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            seq_addr  <= '0;
            iss_left  <= '0;
            rem       <= '0;
            busy      <= 1'b0;
            strm_done <= 1'b0;
        end else begin
            strm_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        state    <= CLEAR;
                        seq_addr <= '0;
                        busy     <= 1'b1;
                    end else if (strm_start) begin
                        seq_addr <= strm_base;
                        iss_left <= strm_len;
                        rem      <= strm_len;
                        if (strm_len == '0) begin
                            state     <= DONE;
                            strm_done <= 1'b1;
                        end else begin
                            state <= STREAM;
                            busy  <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (clr_we) begin
                        seq_addr <= seq_addr + ADDR_ONE;
                        if (seq_addr == '1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                STREAM: begin
                    if (strm_re) begin
                        seq_addr <= seq_addr + ADDR_ONE;
                        iss_left <= iss_left - LEN_ONE;
                    end
                    if (pop) begin
                        rem <= rem - LEN_ONE;
                        if (rem == LEN_ONE) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            strm_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    cnn_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (strm_rd_q),
        .in_data   (ram_q),
        .out_valid (strm_valid),
        .out_data  (strm_data),
        .out_ready (strm_ready),
        .level     (level)
    );

endmodule

// File: tb/tb_cnn_mem_bank.sv
// Directed bench for cnn_mem_bank (DATA_W = 8, DEPTH = 256).
module tb_cnn_mem_bank;

    logic       clk;
    logic       reset;
    logic       chipselect;
    logic       write;
    logic       read;
    logic [7:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       readdatavalid;
    logic       clear;
    logic       strm_start;
    logic [7:0] strm_base;
    logic [8:0] strm_len;
    logic [7:0] strm_data;
    logic       strm_valid;
    logic       strm_ready;
    logic       busy;
    logic       strm_done;

    int checks;
    int failures;

    // Expected array contents, updated by every host write and clear.
    logic [7:0] model [256];

    cnn_mem_bank #(
        .DATA_W (8),
        .DEPTH  (256)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .chipselect    (chipselect),
        .write         (write),
        .read          (read),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .clear         (clear),
        .strm_start    (strm_start),
        .strm_base     (strm_base),
        .strm_len      (strm_len),
        .strm_data     (strm_data),
        .strm_valid    (strm_valid),
        .strm_ready    (strm_ready),
        .busy          (busy),
        .strm_done     (strm_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input logic [7:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 8'(a);
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
        model[a % 256] = d;
    endtask

    task automatic host_read(input int a, input logic [7:0] exp, input string tag);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 8'(a);
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        check({tag, "_rdv"}, readdatavalid, 1);
        check({tag, "_data"}, readdata, exp);
    endtask

    // mode 0: ready held high; 1: ready toggles; 2: ready high plus host
    // reads every other cycle.
    task automatic stream_run(input int base, input int len, input int mode, input string tag);
        int         k, cyc, done_cnt, first_v, first_hs, last_hs, post;
        logic       held, last_prev, rd_prev;
        logic [7:0] held_data;
        logic [7:0] rd_addr_prev;
        k = 0; cyc = 0; done_cnt = 0; post = 0;
        first_v = -1; first_hs = -1; last_hs = -1;
        held = 1'b0; held_data = '0; rd_prev = 1'b0; rd_addr_prev = '0;
        last_prev = (len == 0);
        strm_base  = base[7:0];
        strm_len   = len[8:0];
        strm_start = 1'b1;
        strm_ready = (mode != 1);
        tick();
        strm_start = 1'b0;
        cyc = 1;
        while (cyc < 1000 && post < 4) begin
            if (strm_done) begin
                done_cnt++;
                check({tag, "_done_after_last_hs"}, last_prev, 1);
                check({tag, "_busy_low_at_done"}, busy, 0);
            end
            if (done_cnt > 0) post++;
            if (rd_prev) begin
                check({tag, "_host_rdv"}, readdatavalid, 1);
                check({tag, "_host_data"}, readdata, model[rd_addr_prev]);
            end
            if (held) begin
                check({tag, "_stall_valid"}, strm_valid, 1);
                check({tag, "_stall_data"}, strm_data, held_data);
            end
            if (k >= len) check({tag, "_no_extra_valid"}, strm_valid, 0);
            if (strm_valid && first_v < 0) first_v = cyc;

            strm_ready = (mode == 1) ? cyc[0] : 1'b1;
            rd_prev = 1'b0;
            if (mode == 2 && cyc[0]) begin
                chipselect   = 1'b1;
                read         = 1'b1;
                address      = 8'(50 + (cyc / 2) % 8);
                rd_prev      = 1'b1;
                rd_addr_prev = address;
            end else begin
                chipselect = 1'b0;
                read       = 1'b0;
            end
            last_prev = 1'b0;
            if (strm_valid && strm_ready) begin
                check({tag, "_word"}, strm_data, model[(base + k) % 256]);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                k++;
                last_prev = (k == len);
                held = 1'b0;
            end else begin
                held      = strm_valid;
                held_data = strm_data;
            end
            tick();
            cyc++;
        end
        chipselect = 1'b0;
        read       = 1'b0;
        strm_ready = 1'b0;
        check({tag, "_word_count"}, k, len);
        check({tag, "_done_pulses"}, done_cnt, 1);
        if (mode == 0 && len > 0) begin
            check({tag, "_first_valid_cycle"}, first_v, 2);
            check({tag, "_full_rate"}, last_hs - first_hs, len - 1);
        end
    endtask

    initial begin
        int vcnt;
        checks = 0;
        failures = 0;
        reset = 1'b0;
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0;
        clear = 1'b0; strm_start = 1'b0; strm_base = '0; strm_len = '0;
        strm_ready = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = '0;

        repeat (2) tick();
        check("rst_readdata", readdata, 0);
        check("rst_readdatavalid", readdatavalid, 0);
        check("rst_strm_data", strm_data, 0);
        check("rst_strm_valid", strm_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_strm_done", strm_done, 0);
        reset = 1'b1;
        tick();

        // Write then read, with exactly one cycle of readdatavalid.
        host_write(3, 8'hA5);
        host_read(3, 8'hA5, "wr_then_rd");
        tick();
        check("rdv_single_cycle", readdatavalid, 0);

        // Write and read strobes together: write wins, no response.
        chipselect = 1'b1; write = 1'b1; read = 1'b1;
        address = 8'd3; writedata = 8'h5A;
        tick();
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        model[3] = 8'h5A;
        check("wr_rd_same_no_rdv", readdatavalid, 0);
        host_read(3, 8'h5A, "wr_rd_same_later");

        // Zero-length burst.
        stream_run(0, 0, 0, "len0");

        // Full clear: busy from the cycle after clear through cycle 256.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_busy_first", busy, 1);
        repeat (255) tick();
        check("clear_busy_last", busy, 1);
        tick();
        check("clear_busy_end", busy, 0);
        check("clear_no_done", strm_done, 0);
        for (int i = 0; i < 256; i++) model[i] = '0;
        for (int i = 0; i < 256; i++) host_read(i, 8'h00, "clear_zero");

        // Wrapping burst with ready toggling every cycle.
        host_write(254, 8'd1);
        host_write(255, 8'd2);
        host_write(0, 8'd3);
        host_write(1, 8'd4);
        stream_run(254, 4, 1, "wrap");

        // Full-rate burst, then the same burst under host contention.
        for (int i = 0; i < 16; i++) host_write(100 + i, 8'(8'h80 + i));
        for (int i = 0; i < 8; i++) host_write(50 + i, 8'(8'hC0 + i));
        stream_run(100, 16, 0, "full_rate");
        stream_run(100, 16, 2, "contend");

        // strm_len = DEPTH streams the whole array once.
        stream_run(0, 256, 0, "full_array");

        // Asynchronous reset while word 5 of 10 is on the stream.
        for (int i = 0; i < 10; i++) host_write(i, 8'(8'h30 + i));
        strm_base = 8'd0; strm_len = 9'd10; strm_start = 1'b1; strm_ready = 1'b1;
        tick();
        strm_start = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (strm_valid) begin
                vcnt++;
                if (vcnt == 5) break;
            end
            tick();
        end
        check("rst_mid_word5_seen", vcnt, 5);
        check("rst_mid_word5_data", strm_data, 8'h34);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_strm_valid", strm_valid, 0);
        check("rst_mid_strm_data", strm_data, 0);
        check("rst_mid_readdata", readdata, 0);
        check("rst_mid_readdatavalid", readdatavalid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_strm_done", strm_done, 0);
        tick();
        tick();
        check("rst_hold_no_done", strm_done, 0);
        reset = 1'b1;
        strm_ready = 1'b0;
        tick();
        check("post_rst_idle_done", strm_done, 0);
        check("post_rst_idle_busy", busy, 0);
        stream_run(0, 10, 0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
